wca_rx_iq_packer: RTL and testbench
===================================

Name: wca_rx_iq_packer

Overview:
- Sits directly downstream of the Lime baseband interface.
- Consumes its 24-bit rx_iq / rx_strobe sample stream on the DSP clock and packs each I/Q sample into 16-bit words.
- Buffers the words in a small synchronous FIFO and presents them to the host-transfer stage over a valid/ready handshake.
- Detects and counts samples dropped for lack of buffer space.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in 16-bit words (default 16 words).
- CNT_W, 8, width of saturating drop counter.

Ports:
- clock  in  1  DSP sampling clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- aclr  in  1  synchronous clear of FIFO, staging, flag and counter; mode is a live input and is unaffected.
- enable  in  1  1 = accept samples; 0 = ignore rx_strobe.
- mode  in  1  0 = wide (2 words/sample), 1 = narrow (1 word/sample).
- rx_iq  in  24  {Q[11:0], I[11:0]}, two's complement.
- rx_strobe  in  1  one-clock sample-valid pulse.
- dout  out  16  FIFO head word (show-ahead).
- dout_valid  out  1  head word valid.
- dout_ready  in  1  consumer accepts head word when valid & ready.
- level  out  DEPTH_LOG2+1  words currently stored.
- overflow  out  1  sticky; set on any dropped sample.
- drop_count  out  CNT_W  dropped samples, saturating.

Behaviour:
- Reset (async) and aclr (sync): dout_valid=0, level=0, overflow=0, drop_count=0, staging idle; dout is don't-care while invalid.
- Word formats:
  - Wide word0 = {{4{I[11]}}, I}; wide word1 = {{4{Q[11]}}, Q}.
  - Narrow word = {Q[11:4], I[11:4]} (truncation, no rounding).
- Staging FSM states: IDLE, WR0, WR1.
  - IDLE: on rx_strobe & enable, capture rx_iq into the staging register.
    - Wide mode: requires free space ≥2; if met, go to WR0, else drop.
    - Narrow mode: requires free space ≥1; if met, go to WR0, else drop.
  - WR0: write word0 (wide) or the narrow word.
    - Next state WR1 if wide, else IDLE.
  - WR1: write word1; next state IDLE.
- Free space is evaluated in the strobe cycle, including reads completing that cycle. A sample is never partially written.
- A strobe arriving while the FSM is in WR0 or WR1 is dropped and counted (strobe spacing below 2 or 3 clocks is an upstream error).
- Mode is sampled at capture and held in staging; a mode change mid-sample does not affect the in-flight sample.
- enable deasserting mid-sample: the in-flight sample completes.
- Latency: strobe at edge k → first word written at edge k+1 → dout_valid=1 from edge k+1. In wide mode word1 is written at edge k+2.
- FIFO behaviour:
  - Simultaneous read and write in one cycle is allowed: level unchanged, read pointer and write pointer both advance.
  - Read when empty is ignored.
  - Pointers wrap modulo 2^DEPTH_LOG2; level distinguishes full from empty.
  - dout changes only after an accepted read or a write into an empty FIFO.
- Drop event:
  - overflow is set the cycle after the drop and stays set until reset/aclr.
  - drop_count increments by 1 per dropped sample and saturates at 2^CNT_W-1.
  - A strobe with enable=0 is not a drop.
- aclr and strobe in the same cycle: aclr wins; the sample is discarded and not counted.

Decomposition:
- Shared package wca_iq_pkg holds:
  - MODE_WIDE=0 and MODE_NARROW=1 constants.
  - IQ_W=12.
  - FSM state encodings IDLE/WR0/WR1.
- Natural sub-module wca_sync_fifo: parameterised show-ahead single-clock FIFO with level output. It is reusable by the transmit-side unpacker.

Test Plan:
- Wide, dout_ready=1, strobe with rx_iq=24'hF00100 → words 16'h0100 then 16'hFF00 on consecutive cycles; dout_valid first high at k+1.
- Narrow, rx_iq=24'h7FF800 → single word 16'h7F80; level returns to 0 after the read.
- Wide, dout_ready=0, strobes every 4 clocks → level reaches 16 after 8 samples; the 9th strobe gives overflow=1, drop_count=1, level stays 16. Then 300 more drops → drop_count=255.
- Strobes every 2 clocks in wide mode → every second sample dropped and counted; no torn word pairs in the output.
- Assert aclr with FIFO holding 5 words and a strobe in the same cycle → level=0, dout_valid=0, drop_count=0, with no write afterwards. Then assert async reset mid-WR0 → FSM back to IDLE immediately.
- Simultaneous read/write at level=16 with narrow strobe → sample accepted only if a read completes that cycle; level stays 16.

Source files
------------

// File: rtl/wca_rx_iq_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wca_iq_pkg                                                                 |
// | Shared constants, staging FSM encoding and word helpers for I/Q packing.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package wca_iq_pkg;

  localparam int   IQ_W        = 12;
  localparam logic MODE_WIDE   = 1'b0;
  localparam logic MODE_NARROW = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2
  } stage_state_t;

  // Sign-extend one 12-bit component into a full 16-bit word.
  function automatic logic [15:0] wide_word(input logic [IQ_W-1:0] x);
    return {{(16-IQ_W){x[IQ_W-1]}}, x};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wca_rx_iq_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wca_rx_iq_packer_if                                                        |
// | Sample-in / word-out handshake bundle of the receive I/Q packer.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface wca_rx_iq_packer_if;

  logic [23:0] rx_iq;
  logic        rx_strobe;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;

  modport master (
    output rx_iq, rx_strobe, dout_ready,
    input  dout, dout_valid
  );

  modport slave (
    input  rx_iq, rx_strobe, dout_ready,
    output dout, dout_valid
  );

endinterface
`default_nettype wire

// File: rtl/wca_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wca_sync_fifo                                                              |
// | Single-clock show-ahead FIFO with occupancy level output.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wca_sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  input  wire logic                  aclr,
  input  wire logic                  wr_en,
  input  wire logic [WIDTH-1:0]      wr_data,
  input  wire logic                  rd_en,
  output logic      [WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic      [DEPTH_LOG2:0]   level
);

  localparam int                    DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   C_DEPTH = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_rd;
  logic                  w_wr;

  assign w_rd = rd_en & (r_level != '0) & ~aclr;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign w_wr = wr_en & ((r_level != C_DEPTH) | w_rd) & ~aclr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (aclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data  = r_mem[r_rd_ptr];
  assign rd_valid = (r_level != '0);
  assign level    = r_level;

endmodule
`default_nettype wire

// File: rtl/wca_rx_iq_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wca_rx_iq_packer                                                           |
// | Packs 24-bit I/Q samples into 16-bit words, buffers them, counts drops.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wca_rx_iq_packer
  import wca_iq_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W      = 8
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             aclr,
  input  wire logic             enable,
  input  wire logic             mode,
  wca_rx_iq_packer_if.slave     bus,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [CNT_W-1:0]      drop_count
);

  localparam logic [DEPTH_LOG2+1:0] C_DEPTH = (DEPTH_LOG2+2)'(1 << DEPTH_LOG2);

  stage_state_t          r_state;
  stage_state_t          w_state_nxt;
  logic [23:0]           r_iq;
  logic                  r_mode;
  logic                  w_strobe;
  logic                  w_fifo_valid;
  logic                  w_rd_accept;
  logic [DEPTH_LOG2+1:0] w_free;
  logic [DEPTH_LOG2+1:0] w_need;
  logic                  w_capture;
  logic                  w_drop;
  logic                  w_wr_en;
  logic [15:0]           w_wr_data;

  assign w_strobe    = bus.rx_strobe & enable & ~aclr;
  assign w_rd_accept = w_fifo_valid & bus.dout_ready;
  // Space freed by a read completing this cycle counts toward admission.
  assign w_free      = C_DEPTH - (DEPTH_LOG2+2)'(level) + (DEPTH_LOG2+2)'(w_rd_accept);
  assign w_need      = (mode == MODE_NARROW) ? (DEPTH_LOG2+2)'(1) : (DEPTH_LOG2+2)'(2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (aclr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_data   = '0;
    case (r_state)
      IDLE: begin
        if (w_strobe) begin
          if (w_free >= w_need) begin
            w_capture   = 1'b1;
            w_state_nxt = WR0;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      WR0: begin
        w_wr_en     = 1'b1;
        w_wr_data   = (r_mode == MODE_WIDE) ? wide_word(r_iq[11:0])
                                            : {r_iq[23:16], r_iq[11:4]};
        w_state_nxt = (r_mode == MODE_WIDE) ? WR1 : IDLE;
        w_drop      = w_strobe;
      end
      WR1: begin
        w_wr_en     = 1'b1;
        w_wr_data   = wide_word(r_iq[23:12]);
        w_state_nxt = IDLE;
        w_drop      = w_strobe;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_iq   <= '0;
      r_mode <= MODE_WIDE;
    end else if (aclr) begin
      r_iq   <= '0;
      r_mode <= MODE_WIDE;
    end else if (w_capture) begin
      r_iq   <= bus.rx_iq;
      r_mode <= mode;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (aclr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (w_drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

  wca_sync_fifo #(
    .WIDTH      (16),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .aclr     (aclr),
    .wr_en    (w_wr_en),
    .wr_data  (w_wr_data),
    .rd_en    (bus.dout_ready),
    .rd_data  (bus.dout),
    .rd_valid (w_fifo_valid),
    .level    (level)
  );

  assign bus.dout_valid = w_fifo_valid;

endmodule
`default_nettype wire

// File: tb/tb_wca_rx_iq_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wca_rx_iq_packer                                                        |
// | Directed and random stimulus against a queue-based word/occupancy model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wca_rx_iq_packer;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       aclr;
  logic       enable;
  logic       mode;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drop_count;

  wca_rx_iq_packer_if bus();

  wca_rx_iq_packer #(
    .DEPTH_LOG2 (4),
    .CNT_W      (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .aclr       (aclr),
    .enable     (enable),
    .mode       (mode),
    .bus        (bus.slave),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: words stored in the buffer, words admitted but not yet written.
  logic [15:0] m_fifo[$];
  logic [15:0] m_pend[$];
  int          m_drops;
  bit          m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    m_fifo.delete();
    m_pend.delete();
    m_drops = 0;
    m_ovf   = 0;
  endfunction

  // One clock edge of the model, given the inputs held during the cycle before it.
  function automatic void model_edge(input bit stb, input bit en, input bit md,
                                     input bit [23:0] iq, input bit rdy, input bit clr);
    bit          rd;
    bit          busy;
    int          free;
    int          si;
    int          sq;
    logic [11:0] i;
    logic [11:0] q;
    if (clr) begin
      model_clear();
      return;
    end
    rd   = rdy && (m_fifo.size() > 0);
    free = DEPTH - m_fifo.size() + (rd ? 1 : 0);
    busy = (m_pend.size() > 0);
    if (rd) void'(m_fifo.pop_front());
    if (busy) m_fifo.push_back(m_pend.pop_front());
    if (stb && en) begin
      if (busy || free < (md ? 1 : 2)) begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end else begin
        i = iq[11:0];
        q = iq[23:12];
        if (md) begin
          m_pend.push_back({q[11:4], i[11:4]});
        end else begin
          si = $signed(i);
          sq = $signed(q);
          m_pend.push_back(si[15:0]);
          m_pend.push_back(sq[15:0]);
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".valid"}, bus.dout_valid, m_fifo.size() > 0);
    check_eq({tag, ".level"}, level, m_fifo.size());
    check_eq({tag, ".ovf"}, overflow, m_ovf);
    check_eq({tag, ".drops"}, drop_count, m_drops);
    if (m_fifo.size() > 0) check_eq({tag, ".dout"}, bus.dout, m_fifo[0]);
  endtask

  // Called at a falling edge: drive, advance the model, then check at the next falling edge.
  task automatic step(input bit stb, input bit en, input bit md, input bit [23:0] iq,
                      input bit rdy, input bit clr, input string tag);
    bus.rx_strobe  = stb;
    enable         = en;
    mode           = md;
    bus.rx_iq      = iq;
    bus.dout_ready = rdy;
    aclr           = clr;
    model_edge(stb, en, md, iq, rdy, clr);
    @(negedge clock);
    check_all(tag);
  endtask

  initial begin
    reset          = 1'b1;
    aclr           = 1'b0;
    enable         = 1'b0;
    mode           = 1'b0;
    bus.rx_iq      = '0;
    bus.rx_strobe  = 1'b0;
    bus.dout_ready = 1'b0;
    model_clear();
    @(negedge clock);
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;

    // Wide sample: sign-extended I then Q, first word visible one edge after the strobe.
    step(1, 1, 0, 24'hF00100, 1, 0, "wide.k");
    check_eq("wide.lat", bus.dout_valid, 1'b0);
    step(0, 1, 0, 24'h0, 1, 0, "wide.k1");
    check_eq("wide.w0", bus.dout, 16'h0100);
    step(0, 1, 0, 24'h0, 1, 0, "wide.k2");
    check_eq("wide.w1", bus.dout, 16'hFF00);
    step(0, 1, 0, 24'h0, 1, 0, "wide.k3");

    // Narrow sample: truncated top bytes of Q and I.
    step(1, 1, 1, 24'h7FF800, 1, 0, "nar.k");
    step(0, 1, 1, 24'h0, 1, 0, "nar.k1");
    check_eq("nar.w", bus.dout, 16'h7F80);
    step(0, 1, 1, 24'h0, 1, 0, "nar.k2");
    check_eq("nar.lvl0", level, 5'd0);

    // Fill with wide samples, no reads; the ninth overflows, then saturate the counter.
    for (int s = 0; s < 8; s++) begin
      step(1, 1, 0, 24'($urandom), 0, 0, "fill");
      for (int c = 0; c < 3; c++) step(0, 1, 0, 24'h0, 0, 0, "fill.idle");
    end
    check_eq("fill.lvl16", level, 5'd16);
    step(1, 1, 0, 24'h123456, 0, 0, "ovf9");
    check_eq("ovf9.flag", overflow, 1'b1);
    check_eq("ovf9.cnt", drop_count, 8'd1);
    check_eq("ovf9.lvl", level, 5'd16);
    for (int s = 0; s < 300; s++) step(1, 1, 0, 24'($urandom), 0, 0, "sat");
    check_eq("sat.cnt", drop_count, 8'd255);

    // Full buffer: a narrow sample fits only when a read completes in its strobe cycle.
    step(1, 1, 1, 24'hABCDEF, 0, 0, "full.nord");
    step(1, 1, 1, 24'h5A5A5A, 1, 0, "full.rd");
    step(0, 1, 1, 24'h0, 0, 0, "full.wr");
    check_eq("full.lvl16", level, 5'd16);

    // Synchronous clear with five words held and a coincident strobe.
    step(0, 1, 0, 24'h0, 0, 1, "clr0");
    for (int s = 0; s < 5; s++) begin
      step(1, 1, 1, 24'($urandom), 0, 0, "five");
      step(0, 1, 1, 24'h0, 0, 0, "five.idle");
    end
    check_eq("five.lvl", level, 5'd5);
    step(1, 1, 0, 24'h111111, 0, 1, "clr.stb");
    check_eq("clr.lvl", level, 5'd0);
    check_eq("clr.cnt", drop_count, 8'd0);
    for (int c = 0; c < 3; c++) step(0, 1, 0, 24'h0, 0, 0, "clr.after");
    check_eq("clr.nowr", level, 5'd0);

    // Wide strobes every two clocks: alternate samples drop, pairs stay intact.
    for (int s = 0; s < 20; s++) begin
      step(1, 1, 0, 24'($urandom), 1, 0, "dense");
      step(0, 1, 0, 24'h0, 1, 0, "dense.idle");
    end
    check_eq("dense.cnt", drop_count, 8'd10);
    for (int c = 0; c < 3; c++) step(0, 1, 0, 24'h0, 1, 0, "dense.drain");

    // Asynchronous reset while the staging FSM is mid-sample.
    step(1, 1, 0, 24'h00F0FF, 0, 0, "ar.stb");
    #2 reset = 1'b1;
    model_clear();
    #1 check_all("ar.imm");
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) step(0, 1, 0, 24'h0, 0, 0, "ar.after");
    check_eq("ar.lvl", level, 5'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 2) == 0, ($urandom % 8) != 0, $urandom % 2,
           24'($urandom), ($urandom % 3) != 0, ($urandom % 200) == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
